// File: rtl/eth_rst_pkg.sv
// eth_rst_pkg: state encodings, debug byte layout and width helpers for eth_rst_seq.
package eth_rst_pkg;

    typedef enum logic [2:0] {
        G_COLD = 3'd0,
        G_CORE = 3'd1,
        G_MAC  = 3'd2,
        G_AXIS = 3'd3,
        G_RUN  = 3'd4
    } g_state_e;

    typedef enum logic [1:0] {
        P_HOLD    = 2'd0,
        P_WAIT    = 2'd1,
        P_UP      = 2'd2,
        P_RECOVER = 2'd3
    } p_state_e;

    localparam int DBG_UP_LSB    = 0;
    localparam int DBG_STATE_LSB = 5;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_rst_seq_if.sv
// eth_rst_seq_if: link inputs, debug select and reset/status outputs of eth_rst_seq.
interface eth_rst_seq_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0] link_up;
    logic [2:0]           dbg_sel;
    logic                 core_rst;
    logic [NUM_PORTS-1:0] port_areset;
    logic [NUM_PORTS-1:0] port_rx_rst;
    logic [NUM_PORTS-1:0] port_tx_rst;
    logic                 user_rst;
    logic                 seq_done;
    logic [NUM_PORTS-1:0] port_up;
    logic [7:0]           debug;

    modport master (
        output link_up, dbg_sel,
        input  core_rst, port_areset, port_rx_rst, port_tx_rst, user_rst, seq_done, port_up, debug
    );

    modport slave (
        input  link_up, dbg_sel,
        output core_rst, port_areset, port_rx_rst, port_tx_rst, user_rst, seq_done, port_up, debug
    );
endinterface

// File: rtl/eth_port_mon.sv
// eth_port_mon: per-port link synchroniser, supervision FSM and AXIS reset control.
// With ETH_RST_STATS_EN defined, also keeps a saturating count of recovery entries.
module eth_port_mon
    import eth_rst_pkg::*;
#(
    parameter int DOWN_FILTER    = 156,
    parameter int LOCK_TIMEOUT   = 1562500,
    parameter int RECOVER_CYCLES = 1024
) (
    input  logic       clk156,
    input  logic       sys_rst,
    input  logic       link_up,
    input  logic       go,
    output logic       port_up,
    output logic       axis_rst
`ifdef ETH_RST_STATS_EN
    ,
    output logic [7:0] stats
`endif
);
    localparam int TW = clog2(max2(max2(LOCK_TIMEOUT, RECOVER_CYCLES), DOWN_FILTER) + 1);

    p_state_e      p_q, p_next;
    logic [TW-1:0] t_q, t_next, t_inc;
    logic [1:0]    sync_q;
    logic          link;

    assign link  = sync_q[1];
    assign t_inc = (t_q == '1) ? t_q : t_q + TW'(1);

    // t_q counts lock wait, consecutive link-low cycles or recovery hold, depending on state
    always_comb begin
        p_next = p_q;
        t_next = t_inc;
        case (p_q)
            P_HOLD: begin
                t_next = '0;
                if (go) p_next = P_WAIT;
            end
            P_WAIT:
                if (link) begin
                    p_next = P_UP;
                    t_next = '0;
                end else if (t_q == TW'(LOCK_TIMEOUT - 1)) begin
                    p_next = P_RECOVER;
                    t_next = '0;
                end
            P_UP:
                if (link) t_next = '0;
                else if (t_q == TW'(DOWN_FILTER - 1)) begin
                    p_next = P_RECOVER;
                    t_next = '0;
                end
            default:
                if (t_q == TW'(RECOVER_CYCLES - 1)) begin
                    p_next = P_WAIT;
                    t_next = '0;
                end
        endcase
    end

    always_ff @(posedge clk156 or posedge sys_rst)
        if (sys_rst) begin
            p_q      <= P_HOLD;
            t_q      <= '0;
            sync_q   <= '0;
            port_up  <= 1'b0;
            axis_rst <= 1'b1;
        end else begin
            p_q      <= p_next;
            t_q      <= t_next;
            sync_q   <= {sync_q[0], link_up};
            port_up  <= p_next == P_UP;
            axis_rst <= (p_next == P_HOLD) || (p_next == P_RECOVER);
        end

`ifdef ETH_RST_STATS_EN
    always_ff @(posedge clk156 or posedge sys_rst)
        if (sys_rst) stats <= '0;
        else if (p_q != P_RECOVER && p_next == P_RECOVER && stats != 8'hFF) stats <= stats + 8'd1;
`endif

endmodule

// File: rtl/eth_rst_seq.sv
// eth_rst_seq: staged Ethernet reset release plus per-port link supervision and AXIS recovery.
// ETH_RST_STATS_EN switches debug from state/port_up status to per-port recovery counters.
module eth_rst_seq
    import eth_rst_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int COLD_CYCLES    = 16383,
    parameter int STAGE_GAP      = 16,
    parameter int DOWN_FILTER    = 156,
    parameter int LOCK_TIMEOUT   = 1562500,
    parameter int RECOVER_CYCLES = 1024
) (
    input logic         clk156,
    input logic         sys_rst,
    eth_rst_seq_if.slave bus
);
    localparam int CW = clog2(max2(COLD_CYCLES, STAGE_GAP) + 1);

    g_state_e             g_q, g_next;
    logic [CW-1:0]        cnt_q, cnt_next;
    logic                 core_q, areset_q, user_q, done_q, go;
    logic [NUM_PORTS-1:0] up_q, axis_q;
    logic [7:0]           debug_q;

    // one shared down-counter paces every stage; G_RUN holds until sys_rst
    always_comb begin
        g_next   = g_q;
        cnt_next = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        if (cnt_q == '0 && g_q != G_RUN) begin
            g_next   = g_state_e'(g_q + 3'd1);
            cnt_next = CW'(STAGE_GAP - 1);
        end
    end

    always_ff @(posedge clk156 or posedge sys_rst)
        if (sys_rst) begin
            g_q      <= G_COLD;
            cnt_q    <= CW'(COLD_CYCLES - 1);
            core_q   <= 1'b1;
            areset_q <= 1'b1;
            user_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            g_q      <= g_next;
            cnt_q    <= cnt_next;
            core_q   <= g_next == G_COLD;
            areset_q <= (g_next == G_COLD) || (g_next == G_CORE);
            user_q   <= g_next != G_RUN;
            done_q   <= g_next == G_RUN;
        end

    assign go = (g_q == G_MAC) && (cnt_q == '0);

`ifdef ETH_RST_STATS_EN
    logic [7:0] stats [8];
    for (genvar i = NUM_PORTS; i < 8; i++) begin : g_pad
        assign stats[i] = '0;
    end
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        eth_port_mon #(
            .DOWN_FILTER   (DOWN_FILTER),
            .LOCK_TIMEOUT  (LOCK_TIMEOUT),
            .RECOVER_CYCLES(RECOVER_CYCLES)
        ) u_mon (
            .clk156  (clk156),
            .sys_rst (sys_rst),
            .link_up (bus.link_up[i]),
            .go      (go),
            .port_up (up_q[i]),
            .axis_rst(axis_q[i])
`ifdef ETH_RST_STATS_EN
            ,
            .stats   (stats[i])
`endif
        );
    end

`ifdef ETH_RST_STATS_EN
    always_ff @(posedge clk156 or posedge sys_rst)
        if (sys_rst) debug_q <= '0;
        else debug_q <= stats[bus.dbg_sel];
`else
    logic [4:0] up5;
    assign up5 = 5'(up_q);
    always_ff @(posedge clk156 or posedge sys_rst)
        if (sys_rst) debug_q <= '0;
        else debug_q <= {g_q, up5[DBG_STATE_LSB-1:DBG_UP_LSB]};
`endif

    assign bus.core_rst    = core_q;
    assign bus.port_areset = {NUM_PORTS{areset_q}};
    assign bus.port_rx_rst = axis_q;
    assign bus.port_tx_rst = axis_q;
    assign bus.user_rst    = user_q;
    assign bus.seq_done    = done_q;
    assign bus.port_up     = up_q;
    assign bus.debug       = debug_q;

endmodule

// File: tb/tb_eth_rst_seq.sv
// tb_eth_rst_seq: scoreboard bench for eth_rst_seq with short timing parameters.
// Debug expectations follow ETH_RST_STATS_EN.
module tb_eth_rst_seq;
    localparam int F_CORE = 0, F_ARST = 1, F_RX = 2, F_TX = 3, F_USER = 4, F_DONE = 5, F_UP = 6, F_DBG = 7;
`ifdef ETH_RST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
        string      tag;
    } exp_t;

    logic clk156  = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;
    exp_t sb[$];

    eth_rst_seq_if #(.NUM_PORTS(2)) bus ();

    eth_rst_seq #(
        .NUM_PORTS     (2),
        .COLD_CYCLES   (10),
        .STAGE_GAP     (4),
        .DOWN_FILTER   (3),
        .LOCK_TIMEOUT  (50),
        .RECOVER_CYCLES(8)
    ) dut (
        .clk156 (clk156),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 clk156 = ~clk156;

    // cycle k = k-th rising edge since sys_rst deasserted
    always @(posedge clk156 or posedge sys_rst)
        cyc <= sys_rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic want(input int c, input int s, input logic [7:0] v, input string name);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        e.val = v;
        e.tag = $sformatf("%s@%0d", name, c);
        sb.push_back(e);
    endtask

    task automatic want_reset();
        want(0, F_CORE, 8'd1, "rst_core");
        want(0, F_ARST, 8'd3, "rst_areset");
        want(0, F_RX,   8'd3, "rst_rx");
        want(0, F_TX,   8'd3, "rst_tx");
        want(0, F_USER, 8'd1, "rst_user");
        want(0, F_DONE, 8'd0, "rst_done");
        want(0, F_UP,   8'd0, "rst_up");
        want(0, F_DBG,  8'd0, "rst_debug");
    endtask

    function automatic logic [7:0] field(input int s);
        case (s)
            F_CORE:  return 8'(bus.core_rst);
            F_ARST:  return 8'(bus.port_areset);
            F_RX:    return 8'(bus.port_rx_rst);
            F_TX:    return 8'(bus.port_tx_rst);
            F_USER:  return 8'(bus.user_rst);
            F_DONE:  return 8'(bus.seq_done);
            F_UP:    return 8'(bus.port_up);
            default: return bus.debug;
        endcase
    endfunction

    always @(negedge clk156)
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            check(sb[0].tag, 32'(field(sb[0].sel)), 32'(sb[0].val));
            void'(sb.pop_front());
        end

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk156);
    endtask

    task automatic drop_rst();
        repeat (3) @(negedge clk156);
        #1 sys_rst = 1'b0;
    endtask

    task automatic hit_rst();
        #1 sys_rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.link_up = 2'b11;
        bus.dbg_sel = 3'd0;
        // run A: staged release, short glitch, real drops on port 1
        want_reset();
        want(9,  F_CORE, 8'd1, "core_hold");
        want(10, F_CORE, 8'd0, "core_rel");
        want(13, F_ARST, 8'd3, "areset_hold");
        want(14, F_ARST, 8'd0, "areset_rel");
        want(17, F_RX,   8'd3, "rx_hold");
        want(18, F_RX,   8'd0, "rx_rel");
        want(18, F_TX,   8'd0, "tx_rel");
        want(21, F_UP,   8'd3, "up_both");
        want(21, F_USER, 8'd1, "user_hold");
        want(21, F_DONE, 8'd0, "done_low");
        want(22, F_USER, 8'd0, "user_rel");
        want(22, F_DONE, 8'd1, "done_high");
        want(24, F_DBG,  STATS ? 8'h00 : 8'h83, "debug_run");
        want(34, F_UP,   8'd3, "glitch_up");
        want(36, F_UP,   8'd3, "glitch_up2");
        want(36, F_RX,   8'd0, "glitch_rx");
        want(44, F_UP,   8'd3, "drop_pre_up");
        want(44, F_RX,   8'd0, "drop_pre_rx");
        want(45, F_UP,   8'd1, "drop_up");
        want(45, F_RX,   8'd2, "drop_rx");
        want(45, F_TX,   8'd2, "drop_tx");
        want(48, F_CORE, 8'd0, "drop_core");
        want(48, F_ARST, 8'd0, "drop_areset");
        want(48, F_USER, 8'd0, "drop_user");
        want(52, F_RX,   8'd2, "rec_last");
        want(53, F_RX,   8'd0, "rec_end_rx");
        want(53, F_TX,   8'd0, "rec_end_tx");
        want(54, F_UP,   8'd3, "reup");
        want(66, F_RX,   8'd2, "rec2_rx");
        want(66, F_UP,   8'd1, "rec2_up");
        drop_rst();
        go_to(30); bus.link_up[1] = 1'b0;
        go_to(32); bus.link_up[1] = 1'b1;
        go_to(40); bus.link_up[1] = 1'b0;
        go_to(43); bus.link_up[1] = 1'b1;
        go_to(60); bus.link_up[1] = 1'b0;
        go_to(63); bus.link_up[1] = 1'b1;
        // run B: reset hits while port 1 recovers, then again in G_MAC
        go_to(67); hit_rst();
        bus.link_up = 2'b10;
        want_reset();
        want(10, F_CORE, 8'd0, "b_core_rel");
        want(14, F_ARST, 8'd0, "b_areset_rel");
        want(16, F_RX,   8'd3, "b_rx_hold");
        want(16, F_UP,   8'd0, "b_up_low");
        drop_rst();
        go_to(16); hit_rst();
        // run C: port 0 never locks, port 1 stays up
        want_reset();
        want(18,  F_RX,   8'd0, "c_rx_rel");
        want(18,  F_TX,   8'd0, "c_tx_rel");
        want(19,  F_UP,   8'd2, "c_up");
        want(67,  F_RX,   8'd0, "c_pre_to");
        want(68,  F_RX,   8'd1, "c_to_rx");
        want(68,  F_TX,   8'd1, "c_to_tx");
        want(68,  F_UP,   8'd2, "c_to_up");
        want(75,  F_RX,   8'd1, "c_to_last");
        want(76,  F_RX,   8'd0, "c_to_end");
        want(100, F_USER, 8'd0, "c_user");
        want(100, F_DONE, 8'd1, "c_done");
        want(100, F_CORE, 8'd0, "c_core");
        want(100, F_ARST, 8'd0, "c_areset");
        want(100, F_DBG,  STATS ? 8'h01 : 8'h82, "c_debug");
        want(125, F_RX,   8'd0, "c_pre_to2");
        want(126, F_RX,   8'd1, "c_to2");
        want(130, F_DBG,  STATS ? 8'h02 : 8'h82, "c_debug2");
        want(134, F_RX,   8'd0, "c_to2_end");
        want(184, F_RX,   8'd1, "c_to3");
        want(184, F_UP,   8'd2, "c_up_keep");
        drop_rst();
        go_to(190); hit_rst();
        // run D: 300 forced drops on port 1, then debug readout
        bus.link_up = 2'b11;
        want_reset();
        want(22,   F_DONE, 8'd1, "d_done");
        want(4844, F_DBG,  STATS ? 8'h00 : 8'h83, "d_debug_p0");
        want(4848, F_DBG,  STATS ? 8'hFF : 8'h83, "d_debug_p1");
        want(4848, F_UP,   8'd3, "d_up");
        want(4852, F_DBG,  STATS ? 8'h00 : 8'h83, "d_debug_p5");
        drop_rst();
        for (int k = 0; k < 300; k++) begin
            go_to(30 + 16 * k); bus.link_up[1] = 1'b0;
            go_to(33 + 16 * k); bus.link_up[1] = 1'b1;
        end
        go_to(4846); bus.dbg_sel = 3'd1;
        go_to(4850); bus.dbg_sel = 3'd5;
        go_to(4856);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_rst_seq.md
Name: eth_rst_seq

Overview:
- Parametrised reset and link-supervision sequencer for NUM_PORTS 10G Ethernet ports in the clk156 domain.
- After a cold-start delay, releases resets in stages: shared core/QPLL, per-port MAC/PCS, per-port AXIS rx/tx, user datapath (eth_encap).
- Then supervises each port's link and re-resets only that port's AXIS datapath after a link loss or lock timeout. Other ports keep running.
- Replaces the single fixed cold counter and flat 24-bit reset register in the Ethernet top level.

Parameters:
- NUM_PORTS, 2, number of Ethernet ports supervised (1..8).
- COLD_CYCLES, 16383, cycles core_rst is held after sys_rst deasserts.
- STAGE_GAP, 16, cycles between successive staged releases.
- DOWN_FILTER, 156, consecutive link-low cycles before a port is declared down.
- LOCK_TIMEOUT, 1562500, cycles allowed from port AXIS release to link_up before recovery.
- RECOVER_CYCLES, 1024, cycles a recovering port's AXIS resets are held.

Ports:
- clk156  in  1  156.25 MHz Ethernet core clock.
- sys_rst  in  1  asynchronous, active-high reset.
- link_up  in  NUM_PORTS  per-port PCS block lock AND signal_detect; asynchronous.
- dbg_sel  in  3  port select for debug readout.
- core_rst  out  1  shared core/QPLL reset.
- port_areset  out  NUM_PORTS  per-port MAC/PCS reset.
- port_rx_rst  out  NUM_PORTS  per-port rx AXIS reset, active-high; the top level inverts it for aresetn.
- port_tx_rst  out  NUM_PORTS  per-port tx AXIS reset, active-high.
- user_rst  out  1  user datapath reset.
- seq_done  out  1  staged release complete.
- port_up  out  NUM_PORTS  port link qualified up.
- debug  out  8  status byte.

Behaviour:
- Reset values: every *_rst output and port_areset is all-ones; seq_done, port_up and debug are 0. sys_rst asserting at any time, including mid-sequence or during recovery, immediately forces these values and returns both FSMs to their initial states.
- Every output is driven from a flop; no combinational paths from inputs to outputs.
- Cycle numbering: cycle k is the k-th rising clk156 edge after sys_rst deasserts.
- Global FSM states: G_COLD, G_CORE, G_MAC, G_AXIS, G_RUN. One shared down-counter, width $clog2(max(COLD_CYCLES,STAGE_GAP)+1).
- G_COLD: counts COLD_CYCLES; then core_rst <= 0 at cycle COLD_CYCLES; go to G_CORE.
- G_CORE: after STAGE_GAP, port_areset <= 0 for all ports; go to G_MAC.
- G_MAC: after STAGE_GAP, port_rx_rst and port_tx_rst <= 0 for all ports; go to G_AXIS.
- G_AXIS: after STAGE_GAP, user_rst <= 0 and seq_done <= 1 in the same cycle; go to G_RUN. G_RUN is terminal until sys_rst.
- Input sync: link_up is double-flop synchronised per bit, giving 2 cycles of latency. All link timing below refers to the synchronised signal.
- Per-port FSM states: P_HOLD, P_WAIT, P_UP, P_RECOVER. Each port has its own timer of width $clog2(max(LOCK_TIMEOUT,RECOVER_CYCLES,DOWN_FILTER)+1).
- P_HOLD: stays here until the global FSM leaves G_MAC; then enter P_WAIT with the timer cleared.
- P_WAIT: link high -> P_UP, port_up <= 1. Timer reaching LOCK_TIMEOUT -> P_RECOVER.
- P_UP: counts consecutive link-low cycles; any high cycle clears the count. Count reaching DOWN_FILTER -> P_RECOVER, port_up <= 0.
- P_RECOVER: that port's rx_rst and tx_rst are 1 for exactly RECOVER_CYCLES cycles, then deassert; go to P_WAIT.
- Recovery never touches core_rst, port_areset, user_rst or other ports. Link events during P_RECOVER are ignored.
- Simultaneous timeout on several ports: each recovers independently in the same cycle.
- Timers saturate and never wrap.
- debug, without stats: [7:5] global state code, [4:0] port_up[4:0] zero-extended. dbg_sel is ignored.

Optional Feature:
- Macro: ETH_RST_STATS_EN.
- Defined: each port keeps an 8-bit saturating counter, incremented on every entry to P_RECOVER and cleared only by sys_rst. debug = counter of port dbg_sel; a dbg_sel >= NUM_PORTS returns 8'h00.
- Undefined: no counters are built; debug behaves as described in Behaviour.

Decomposition:
- Package eth_rst_pkg: global and port state enums with fixed encodings (G_COLD=0 .. G_RUN=4, P_HOLD=0 .. P_RECOVER=3), a clog2 helper, and the debug field offsets.
- Sub-module eth_port_mon: one instance per port, generated NUM_PORTS times. It contains the synchroniser, port FSM, timer and the optional stats counter.

Test Plan (COLD_CYCLES=10, STAGE_GAP=4, DOWN_FILTER=3, LOCK_TIMEOUT=50, RECOVER_CYCLES=8, NUM_PORTS=2):
- Release sys_rst with link_up=2'b11 -> core_rst falls at cycle 10, port_areset at 14, rx/tx_rst at 18, user_rst falls and seq_done rises at 22; port_up=2'b11 by cycle 21.
- Port 1 link low for 2 cycles, then high -> no recovery, port_up stays 2'b11.
- Port 1 link low for 3 cycles -> port_up[1]=0, rx_rst[1] and tx_rst[1] high for exactly 8 cycles; port 0 and user_rst unchanged.
- Port 0 link held low from start -> recovery entered 50 cycles after cycle 18, repeating every 58 cycles; port 1 unaffected.
- sys_rst pulse while port 1 is in P_RECOVER and while the global FSM is in G_MAC -> all outputs return to reset values within the pulse, and the full sequence restarts from cycle 0.
- With ETH_RST_STATS_EN, 300 forced drops on port 1 and dbg_sel=1 -> debug=8'hFF; dbg_sel=5 -> debug=8'h00.
